imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory address width (256 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-006 SHALL have port word_count  input  8  number of words to load, latched on start; 0 means 256.
REQ-007 SHALL have port in_valid  input  1  byte-stream source has a byte.
REQ-008 SHALL have port in_data  input  8  byte-stream data, first byte of a word is most significant.
REQ-009 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port wr_en  output  1  instruction-memory write strobe.
REQ-011 SHALL have port wr_addr  output  ADDR_W  instruction-memory write address.
REQ-012 SHALL have port wr_data  output  DATA_W  instruction word to write.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-015 SHALL have port cpu_hold  output  1  holds fetch/PC while memory is being written.

Function
REQ-016 SHALL implement states IDLE, RECV, WRITE, DONE.
REQ-017 SHALL, in IDLE with start=1, latch word_count (0 -> 256), clear address to 0 and byte counter to 0, and go to RECV next cycle.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL drive in_ready=1 only in RECV; a byte transfers on a cycle where in_valid and in_ready are both 1.
REQ-020 SHALL shift each accepted byte in as word <= {word[23:0], in_data} and increment a 2-bit byte counter.
REQ-021 SHALL, on acceptance of the 4th byte, go to WRITE on the next cycle, with no bytes accepted in WRITE.
REQ-022 SHALL, in WRITE, assert wr_en for exactly one cycle with wr_addr = current address and wr_data = assembled word.
REQ-023 SHALL, leaving WRITE, increment the address mod 256 and decrement the remaining-word count; go to DONE if the count reaches 0, otherwise to RECV.
REQ-024 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-025 SHALL drive busy=1 and cpu_hold=1 in RECV, WRITE, and DONE, and 0 in IDLE.
REQ-026 SHALL hold state while in RECV with in_valid=0, for an unbounded number of cycles, without modifying the partial word.
REQ-027 SHALL, for word_count=0, write addresses 0..255 exactly once, ending with address wrapped to 0.
REQ-028 SHALL drive wr_addr/wr_data to 0 whenever wr_en=0.

Reset
REQ-029 SHALL, on reset assertion at any time including mid-load, go immediately to IDLE with in_ready, wr_en, busy, done, cpu_hold, wr_addr, and wr_data all 0.
REQ-030 SHALL discard any partial word and remaining count on reset, with no write issued afterward.

Structure
REQ-031 SHALL take the state enumeration, BYTES_PER_WORD=4, and IMEM_DEPTH=256 from a shared package, imem_pkg.
REQ-032 SHALL contain one sub-module, word_assembler (byte shift register plus byte counter, "word complete" flag).
REQ-033 SHALL connect its wr_* port to a write port of the instruction memory; the existing combinational read port is unchanged.

Verification
REQ-034 SHALL cover: start, word_count=2, bytes 12 34 56 78 9A BC DE F0 back-to-back -> writes 0x12345678@0, 0x9ABCDEF0@1, a done pulse, then busy=0.
REQ-035 SHALL cover: word_count=1, in_valid toggled 1/0 every cycle -> a single write 0xDEADBEEF@0 issued one cycle after the 4th accepted byte, with in_ready=0 during WRITE.
REQ-036 SHALL cover: word_count=0 with 1024 incrementing bytes -> 256 writes to addresses 0..255, word k = {4k,4k+1,4k+2,4k+3} mod 256, then done.
REQ-037 SHALL cover: reset asserted after the 2nd byte of word 0 -> all outputs 0 immediately, with no wr_en; a later start with word_count=1 writes a fresh word @0.
REQ-038 SHALL cover: start pulsed repeatedly during a word_count=3 load -> exactly 3 writes and one done pulse.
REQ-039 SHALL cover: read-back through the instruction-memory read port after a load -> the instruction at each PC matches the loaded words.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory byte-stream loader.
package imem_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IMEM_DEPTH     = 256;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);
    localparam int unsigned REMAIN_W       = $clog2(IMEM_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE
    } load_state_t;

    // A word_count of zero requests a full memory image.
    function automatic logic [REMAIN_W-1:0] words_to_load(input logic [7:0] word_count);
        return (word_count == 8'd0) ? REMAIN_W'(IMEM_DEPTH) : REMAIN_W'(word_count);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte shift register with a byte counter; flags the byte that completes a word.
module word_assembler
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_complete
);

    logic [DATA_W-1:0] word_q, word_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    always_comb begin
        word_d = word_q;
        bcnt_d = bcnt_q;
        if (clear) begin
            word_d = '0;
            bcnt_d = '0;
        end else if (shift_en) begin
            word_d = {word_q[DATA_W-BYTE_W-1:0], byte_in};
            bcnt_d = bcnt_q + BCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            bcnt_q <= '0;
        end else begin
            word_q <= word_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign word          = word_q;
    assign word_complete = shift_en && (bcnt_q == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction memory from a byte stream, holding the CPU until the image is written.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold
);

    load_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [REMAIN_W-1:0] remain_q, remain_d;
    logic                accept;
    logic                clear;
    logic                word_complete;
    logic [DATA_W-1:0]   word;

    assign accept = in_valid && (state_q == ST_RECV);

    word_assembler #(
        .DATA_W(DATA_W)
    ) u_word_assembler (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .shift_en     (accept),
        .byte_in      (in_data),
        .word         (word),
        .word_complete(word_complete)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        clear    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remain_d = words_to_load(word_count);
                    addr_d   = '0;
                    clear    = 1'b1;
                    state_d  = ST_RECV;
                end
            end
            ST_RECV: begin
                if (word_complete) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Address width sets the wrap point, so a full image ends back at 0.
                addr_d   = addr_q + ADDR_W'(1);
                remain_d = remain_q - REMAIN_W'(1);
                state_d  = (remain_q == REMAIN_W'(1)) ? ST_DONE : ST_RECV;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        done     = 1'b0;
        busy     = (state_q != ST_IDLE);
        cpu_hold = (state_q != ST_IDLE);
        case (state_q)
            ST_RECV:  in_ready = 1'b1;
            ST_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = addr_q;
                wr_data = word;
            end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader with a behavioural instruction-memory model.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        word_count;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              cpu_hold;

    imem_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .word_count(word_count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  stim_q[$];
    logic [31:0] imem[256];
    logic [31:0] ref_mem[256];

    int   n_checks     = 0;
    int   n_errors     = 0;
    int   cyc          = 0;
    int   last_accept  = -10;
    int   done_cnt     = 0;
    int   wr_cnt       = 0;
    int   exp_wr_total = 0;
    logic done_prev    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every write and acts as the instruction memory.
    always @(negedge clk) begin
        wr_t e;
        if (wr_en) begin
            wr_cnt++;
            chk("wr_latency", 64'(cyc), 64'(last_accept + 1));
            chk("ready_low_in_write", in_ready, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
            end
            imem[wr_addr] = wr_data;
        end else begin
            chk("wr_bus_zero_when_idle", {wr_addr, wr_data}, 0);
        end
        chk("cpu_hold_eq_busy", cpu_hold, busy);
        if (in_ready) chk("ready_implies_busy", busy, 1);
        if (done) begin
            done_cnt++;
            chk("done_single_cycle", done_prev, 0);
            chk("busy_during_done", busy, 1);
        end
        done_prev = done;
        if (in_valid && in_ready) last_accept = cyc;
    end

    // mode 0: back-to-back, 1: toggle, 2: random gaps, 3: long stall mid-word
    task automatic do_load(input logic [7:0] wc, input int mode, input bit spam);
        int nw;
        int idx;
        int t;
        int d0;
        wr_t e;
        nw  = (wc == 8'd0) ? 256 : int'(wc);
        idx = 0;
        t   = 0;
        for (int k = 0; k < nw; k++) begin
            e.addr = 8'(k);
            e.data = {stim_q[4*k], stim_q[4*k+1], stim_q[4*k+2], stim_q[4*k+3]};
            exp_q.push_back(e);
            ref_mem[k] = e.data;
        end
        exp_wr_total += nw;
        d0 = done_cnt;
        start      = 1'b1;
        word_count = wc;
        @(posedge clk); #1;
        start      = 1'b0;
        word_count = 8'($urandom);
        chk("busy_after_start", busy, 1);
        while (done_cnt == d0 && t < 24 * nw + 100) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (t % 2 == 0);
                2:       in_valid = ($urandom_range(0, 3) != 0);
                default: in_valid = !(t >= 3 && t < 40);
            endcase
            in_data = (in_valid && idx < stim_q.size()) ? stim_q[idx] : 8'($urandom);
            if (spam) start = 1'($urandom);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("one_done_per_load", 64'(done_cnt - d0), 1);
        chk("busy_low_after_done", busy, 0);
        chk("ready_low_after_done", in_ready, 0);
        chk("all_writes_seen", 64'(exp_q.size()), 0);
        for (int k = 0; k < nw; k++) chk("imem_readback", imem[k], ref_mem[k]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        word_count = 8'd0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        #1;
        chk("reset_outputs", {in_ready, wr_en, busy, done, cpu_hold, wr_addr, wr_data}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Two words back-to-back
        stim_q = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        do_load(8'd2, 0, 1'b0);

        // Single word, in_valid toggling
        stim_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_load(8'd1, 1, 1'b0);

        // Full 256-word image of incrementing bytes
        stim_q.delete();
        for (int i = 0; i < 1024; i++) stim_q.push_back(8'(i));
        do_load(8'd0, 0, 1'b0);

        // Reset after the second byte of word 0
        start      = 1'b1;
        word_count = 8'd1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h11;
        @(posedge clk); #1;
        in_data  = 8'h22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midload_reset_outputs", {in_ready, wr_en, busy, done, cpu_hold, wr_addr, wr_data}, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("no_write_after_reset", 64'(wr_cnt), 64'(exp_wr_total));
        stim_q = {8'h5A, 8'hC3, 8'h0F, 8'h81};
        do_load(8'd1, 0, 1'b0);

        // Start spammed throughout a three-word load
        stim_q.delete();
        for (int i = 0; i < 12; i++) stim_q.push_back(8'($urandom));
        do_load(8'd3, 2, 1'b1);

        // Random loads
        for (int r = 0; r < 6; r++) begin
            int wc;
            wc = $urandom_range(1, 6);
            stim_q.delete();
            for (int i = 0; i < 4 * wc; i++) stim_q.push_back(8'($urandom));
            do_load(8'(wc), $urandom_range(0, 3), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        chk("total_writes", 64'(wr_cnt), 64'(exp_wr_total));
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
